// File: rtl/img_proc_pkg.sv
// Shared definitions for the image-processing pipeline: window FSM states,
// line-buffer count and the row-major byte layout of a 3x3 window.
package img_proc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } win_state_t;

    localparam int NUM_LINES = 4;
    localparam int WIN_TAPS  = 9;

    // First byte index of each window row; taps c, c+1, c+2 follow in order.
    localparam int WIN_ROW_TOP = 0;
    localparam int WIN_ROW_MID = 3;
    localparam int WIN_ROW_BOT = 6;

    function automatic int win_row_base(input int row);
        case (row)
            0:       return WIN_ROW_TOP;
            1:       return WIN_ROW_MID;
            default: return WIN_ROW_BOT;
        endcase
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage with a self-advancing write pointer and three
// combinational read taps at columns c..c+2, zero beyond the right edge.
module line_buffer #(
    parameter int IMG_WIDTH = 512,
    parameter int PIX_W     = 8,
    parameter int PTR_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [PIX_W-1:0]   i_data,
    input  logic               i_data_valid,
    input  logic [PTR_W-1:0]   i_rd_ptr,
    output logic [3*PIX_W-1:0] o_data
);

    logic [PIX_W-1:0] mem [IMG_WIDTH];
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
        end else if (i_data_valid) begin
            wr_ptr <= (wr_ptr == PTR_W'(IMG_WIDTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_data_valid) begin
            mem[wr_ptr] <= i_data;
        end
    end

    for (genvar t = 0; t < 3; t++) begin : g_tap
        logic [PTR_W:0] col;
        assign col = {1'b0, i_rd_ptr} + (PTR_W + 1)'(t);
        assign o_data[t*PIX_W +: PIX_W] =
            (col < (PTR_W + 1)'(IMG_WIDTH)) ? mem[col[PTR_W-1:0]] : '0;
    end

endmodule

// File: rtl/image_window_ctrl.sv
// Rotating four-line buffer that emits one 3x3 window per cycle once three
// full lines are held, with a per-line interrupt and sticky overflow flag.
module image_window_ctrl
    import img_proc_pkg::*;
#(
    parameter int IMG_WIDTH = 512,
    parameter int PIX_W     = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [PIX_W-1:0]          i_pixel_data,
    input  logic                      i_pixel_data_valid,
    output logic [WIN_TAPS*PIX_W-1:0] o_pixel_data,
    output logic                      o_pixel_data_valid,
    output logic                      o_intr,
    output logic                      o_overflow
);

    localparam int PTR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int SEL_W = $clog2(NUM_LINES);
    localparam int CNT_W = $clog2(NUM_LINES * IMG_WIDTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [SEL_W-1:0] wr_sel;
    logic [SEL_W-1:0] rd_sel;
    logic [CNT_W-1:0] count;
    win_state_t       state;

    logic full;
    logic wr_accept;
    logic rd_issue;
    logic rd_last;

    logic [NUM_LINES-1:0]      buf_wr_en;
    logic [3*PIX_W-1:0]        buf_taps [NUM_LINES];
    logic [WIN_TAPS*PIX_W-1:0] win_p0;
    logic                      vld_p1;
    logic                      last_p1;

    assign rd_issue  = (state == READ);
    assign rd_last   = rd_issue && (rd_ptr == PTR_W'(IMG_WIDTH - 1));
    // A read in the same cycle frees a slot, so only a read-less cycle is full.
    assign full      = (count == CNT_W'(NUM_LINES * IMG_WIDTH)) && !rd_issue;
    assign wr_accept = i_pixel_data_valid && !full;

    for (genvar b = 0; b < NUM_LINES; b++) begin : g_buf
        assign buf_wr_en[b] = wr_accept && (wr_sel == SEL_W'(b));

        line_buffer #(
            .IMG_WIDTH (IMG_WIDTH),
            .PIX_W     (PIX_W),
            .PTR_W     (PTR_W)
        ) u_line_buffer (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_data       (i_pixel_data),
            .i_data_valid (buf_wr_en[b]),
            .i_rd_ptr     (rd_ptr),
            .o_data       (buf_taps[b])
        );
    end

    // Stage p0: oldest buffer forms the top row, the next two follow mod 4.
    always_comb begin
        win_p0 = '0;
        for (int r = 0; r < 3; r++) begin
            win_p0[win_row_base(r)*PIX_W +: 3*PIX_W] = buf_taps[rd_sel + SEL_W'(r)];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            wr_sel     <= '0;
            rd_ptr     <= '0;
            rd_sel     <= '0;
            count      <= '0;
            state      <= IDLE;
            o_overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                if (wr_ptr == PTR_W'(IMG_WIDTH - 1)) begin
                    wr_ptr <= '0;
                    wr_sel <= wr_sel + SEL_W'(1);
                end else begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
            if (i_pixel_data_valid && full) begin
                o_overflow <= 1'b1;
            end
            count <= count + CNT_W'(wr_accept) - CNT_W'(rd_issue);
            case (state)
                IDLE: begin
                    if (count >= CNT_W'(3 * IMG_WIDTH)) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (rd_last) begin
                        rd_ptr <= '0;
                        rd_sel <= rd_sel + SEL_W'(1);
                        state  <= IDLE;
                    end else begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: registered window; the interrupt trails the final window by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1       <= 1'b0;
            last_p1      <= 1'b0;
            o_intr       <= 1'b0;
            o_pixel_data <= '0;
        end else begin
            vld_p1  <= rd_issue;
            last_p1 <= rd_last;
            o_intr  <= last_p1;
            if (rd_issue) begin
                o_pixel_data <= win_p0;
            end
        end
    end

    assign o_pixel_data_valid = vld_p1;

endmodule

// File: tb/tb_image_window_ctrl.sv
// Directed bench for image_window_ctrl: window contents, latency, interrupts,
// right-edge padding, mid-pass reset and overflow on a narrow instance.
module tb_image_window_ctrl;

    localparam int W  = 512;
    localparam int WS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vld;
    logic [7:0]  pix;
    logic [71:0] win;
    logic        win_vld;
    logic        intr;
    logic        ovf;

    logic        s_rst;
    logic        s_vld;
    logic [7:0]  s_pix;
    logic [71:0] s_win;
    logic        s_win_vld;
    logic        s_intr;
    logic        s_ovf;

    image_window_ctrl #(.IMG_WIDTH(W), .PIX_W(8)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_pixel_data       (pix),
        .i_pixel_data_valid (vld),
        .o_pixel_data       (win),
        .o_pixel_data_valid (win_vld),
        .o_intr             (intr),
        .o_overflow         (ovf)
    );

    image_window_ctrl #(.IMG_WIDTH(WS), .PIX_W(8)) dut_s (
        .i_clk              (clk),
        .i_rst              (s_rst),
        .i_pixel_data       (s_pix),
        .i_pixel_data_valid (s_vld),
        .o_pixel_data       (s_win),
        .o_pixel_data_valid (s_win_vld),
        .o_intr             (s_intr),
        .o_overflow         (s_ovf)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [71:0] win_q [$];
    int          vcyc_q [$];
    int          intr_q [$];

    typedef struct {
        string       name;
        int          idx;
        logic [71:0] exp;
    } vec_t;
    vec_t tbl [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (win_vld) begin
            win_q.push_back(win);
            vcyc_q.push_back(cyc);
        end
        if (intr) intr_q.push_back(cyc);
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] mkw(input int t0, t1, t2, m0, m1, m2, b0, b1, b2);
        return {8'(b2), 8'(b1), 8'(b0), 8'(m2), 8'(m1), 8'(m0), 8'(t2), 8'(t1), 8'(t0)};
    endfunction

    function automatic logic [7:0] pix_val(input int mode, input int l, input int c);
        case (mode)
            0:       return 8'((l * W + c) % 256);
            1:       return 8'((l + 1) * 10);
            default: return 8'((l << 5) + (c & 31));
        endcase
    endfunction

    task automatic clear_mon();
        win_q.delete();
        vcyc_q.delete();
        intr_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic stream(input int nlines, input int mode, output int last_cyc);
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < W; c++) begin
                vld = 1'b1;
                pix = pix_val(mode, l, c);
                @(posedge clk);
                #1;
            end
        end
        vld = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic add_vec(input string name, input int idx, input logic [71:0] exp);
        vec_t v;
        v.name = name;
        v.idx  = idx;
        v.exp  = exp;
        tbl.push_back(v);
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            check(tbl[i].name, (tbl[i].idx < win_q.size()) ? win_q[tbl[i].idx] : 72'hx, tbl[i].exp);
        end
        tbl.delete();
    endtask

    int lc;

    initial begin
        rst   = 1'b1;
        vld   = 1'b0;
        pix   = '0;
        s_rst = 1'b1;
        s_vld = 1'b0;
        s_pix = '0;

        // Reset state
        do_reset();
        check("rst data", win, 72'd0);
        check("rst valid", 72'(win_vld), 72'd0);
        check("rst intr", 72'(intr), 72'd0);
        check("rst ovf", 72'(ovf), 72'd0);

        // Three lines of index mod 256
        stream(3, 0, lc);
        repeat (W + 20) @(posedge clk);
        #1;
        check("t1 nvalid", 72'(win_q.size()), 72'(512));
        check("t1 latency", 72'((vcyc_q.size() > 0) ? vcyc_q[0] - lc : -1), 72'(2));
        check("t1 contiguous", 72'((vcyc_q.size() > 0) ? vcyc_q[vcyc_q.size()-1] - vcyc_q[0] : -1), 72'(511));
        check("t1 nintr", 72'(intr_q.size()), 72'(1));
        check("t1 intr time",
              72'((intr_q.size() > 0 && vcyc_q.size() > 0) ? intr_q[0] - vcyc_q[vcyc_q.size()-1] : -1), 72'(1));
        add_vec("t1 c0",   0,   mkw(0, 1, 2, 0, 1, 2, 0, 1, 2));
        add_vec("t1 c253", 253, mkw(253, 254, 255, 253, 254, 255, 253, 254, 255));
        add_vec("t1 c254", 254, mkw(254, 255, 0, 254, 255, 0, 254, 255, 0));
        add_vec("t1 c510", 510, mkw(254, 255, 0, 254, 255, 0, 254, 255, 0));
        add_vec("t1 c511", 511, mkw(255, 0, 0, 255, 0, 0, 255, 0, 0));
        run_table();

        // Right edge with constant lines 10/20/30
        do_reset();
        stream(3, 1, lc);
        repeat (W + 20) @(posedge clk);
        #1;
        check("t2 nvalid", 72'(win_q.size()), 72'(512));
        add_vec("t2 c0",   0,   mkw(10, 10, 10, 20, 20, 20, 30, 30, 30));
        add_vec("t2 c510", 510, mkw(10, 10, 0, 20, 20, 0, 30, 30, 0));
        add_vec("t2 c511", 511, mkw(10, 0, 0, 20, 0, 0, 30, 0, 0));
        run_table();
        check("t2 hold data", win, mkw(10, 0, 0, 20, 0, 0, 30, 0, 0));
        check("t2 idle valid", 72'(win_vld), 72'd0);

        // Five lines streamed continuously: three passes with buffer rotation
        do_reset();
        stream(5, 2, lc);
        repeat (W + 30) @(posedge clk);
        #1;
        check("t3 nvalid", 72'(win_q.size()), 72'(1536));
        check("t3 nintr", 72'(intr_q.size()), 72'(3));
        check("t3 intr gap", 72'((intr_q.size() > 1) ? intr_q[1] - intr_q[0] : -1), 72'(513));
        add_vec("t3 p0 c5",   5,          mkw(5, 6, 7, 37, 38, 39, 69, 70, 71));
        add_vec("t3 p1 c0",   512,        mkw(32, 33, 34, 64, 65, 66, 96, 97, 98));
        add_vec("t3 p1 c30",  512 + 30,   mkw(62, 63, 32, 94, 95, 64, 126, 127, 96));
        add_vec("t3 p2 c0",   1024,       mkw(64, 65, 66, 96, 97, 98, 128, 129, 130));
        add_vec("t3 p2 c511", 1024 + 511, mkw(95, 0, 0, 127, 0, 0, 159, 0, 0));
        run_table();

        // Reset in the middle of a read pass
        do_reset();
        stream(3, 1, lc);
        repeat (50) @(posedge clk);
        #1;
        check("t4 reading", 72'(win_vld), 72'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t4 data", win, 72'd0);
        check("t4 valid", 72'(win_vld), 72'd0);
        check("t4 intr", 72'(intr), 72'd0);
        check("t4 state", 72'(dut.state), 72'd0);
        clear_mon();
        repeat (W + 20) @(posedge clk);
        #1;
        check("t4 quiet valid", 72'(win_q.size()), 72'd0);
        check("t4 quiet intr", 72'(intr_q.size()), 72'd0);
        stream(3, 0, lc);
        repeat (W + 20) @(posedge clk);
        #1;
        check("t4 nvalid", 72'(win_q.size()), 72'(512));
        check("t4 nintr", 72'(intr_q.size()), 72'(1));
        add_vec("t4 c0",   0,   mkw(0, 1, 2, 0, 1, 2, 0, 1, 2));
        add_vec("t4 c511", 511, mkw(255, 0, 0, 255, 0, 0, 255, 0, 0));
        run_table();

        // Overflow on the 4-pixel-wide instance under continuous input
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        check("t5 rst ovf", 72'(s_ovf), 72'd0);
        s_vld = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            s_pix = 8'(k);
            @(posedge clk);
            #1;
            if (k == 32) check("t5 ovf before full", 72'(s_ovf), 72'd0);
            if (k == 33) check("t5 ovf set", 72'(s_ovf), 72'd1);
        end
        check("t5 count full", 72'(dut_s.count), 72'(4 * WS));
        s_vld = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t5 ovf sticky", 72'(s_ovf), 72'd1);
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        check("t5 ovf cleared", 72'(s_ovf), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_window_ctrl.md
Name: image_window_ctrl

Overview:
- Buffers a raster pixel stream in four rotating line buffers.
- Once three full lines are held, issues one 3x3 window per cycle, packed as 72 bits, to the downstream convolution datapath.
- Pulses an interrupt after each line is consumed so the host DMA sends the next line.
- Sits between the AXI-Stream input adapter and the box-blur/convolution stage.

Parameters:
- IMG_WIDTH, 512, pixels per line; also the depth of each line buffer (power of two not required).
- PIX_W, 8, bits per pixel. The window output is 9*PIX_W wide.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_pixel_data  input  PIX_W  incoming pixel, raster order.
- i_pixel_data_valid  input  1  i_pixel_data is valid this cycle.
- o_pixel_data  output  9*PIX_W  3x3 window to the convolution stage.
- o_pixel_data_valid  output  1  o_pixel_data is valid this cycle.
- o_intr  output  1  one-cycle pulse: one buffered line fully consumed.
- o_overflow  output  1  sticky: a pixel was dropped because all four buffers were full.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - o_pixel_data=0, o_pixel_data_valid=0, o_intr=0, o_overflow=0.
  - Write pointer, read pointer, write select and read select = 0; pixel count = 0; FSM = IDLE.
  - Line buffer contents are not cleared.
  - Reset mid-line discards all buffered pixels.
- Write side:
  - Each accepted valid pixel is stored at wr_ptr of buffer wr_sel; wr_ptr increments.
  - When wr_ptr = IMG_WIDTH-1 and a pixel is accepted, wr_ptr wraps to 0 and wr_sel advances mod 4.
- Pixel count (0..4*IMG_WIDTH):
  - Each cycle: count += wr_accept - rd_issue. A simultaneous write and read leaves count unchanged.
- Full condition:
  - Full is count = 4*IMG_WIDTH with no read issued that cycle.
  - A valid pixel arriving while full is dropped (no pointer change) and sets o_overflow until reset.
- FSM:
  - IDLE: when count >= 3*IMG_WIDTH, go to READ next cycle.
  - READ:
    - Issue one read per cycle with rd_ptr = 0..IMG_WIDTH-1.
    - After the read at rd_ptr = IMG_WIDTH-1: rd_ptr returns to 0, rd_sel advances mod 4, the FSM returns to IDLE, and o_intr = 1 on the next cycle for exactly one cycle.
  - Each READ pass therefore issues exactly IMG_WIDTH consecutive reads; there are no gaps.
- Window assembly:
  - Top row = buffer rd_sel (oldest), middle = rd_sel+1, bottom = rd_sel+2 (mod 4).
  - Each row supplies taps at columns c, c+1, c+2, where c = rd_ptr.
  - Any column >= IMG_WIDTH reads as 0 (right-edge zero padding).
  - Byte k of o_pixel_data (bits k*PIX_W +: PIX_W):
    - k=0..2: top row, columns c..c+2.
    - k=3..5: middle row, columns c..c+2.
    - k=6..8: bottom row, columns c..c+2.
- Latency:
  - o_pixel_data and o_pixel_data_valid are registered, one cycle after the read is issued.
  - o_pixel_data_valid is high exactly on cycles following an issued read.
  - o_pixel_data holds its last value when not valid.
- Write and read proceed concurrently. The fourth buffer is written while the other three are read. The writer never overwrites a buffer under read because of the full check.

Decomposition:
- Shared package img_proc_pkg holds:
  - the FSM state typedef (IDLE, READ);
  - NUM_LINES=4 and WIN_TAPS=9;
  - the window byte-index constants (row-major, top-left = 0).
  - The convolution blocks reuse the same byte-order constants.
- Sub-module line_buffer, instantiated four times:
  - Ports: i_clk, i_rst, i_data, i_data_valid (write), i_rd_ptr, o_data (3*PIX_W, combinational taps c..c+2 with zero padding).
  - Contains its own write pointer and a storage array of depth IMG_WIDTH.
- Top level holds the selects, count, FSM, mux to 72 bits, output registers and interrupt.

Test Plan:
- Reset then stream 3*512 pixels, pixel value = (index mod 256) -> first o_pixel_data_valid 2 cycles after the 1536th write (IDLE→READ, then output register) -> first window bytes {0,1,2 | 0,1,2 | 0,1,2}; 512 contiguous valid cycles; o_intr high one cycle afterward.
- Right edge with constant line values 10/20/30 -> window at c=511 is {10,0,0,20,0,0,30,0,0}; at c=510 it is {10,10,0,20,20,0,30,30,0}.
- Stream 5 lines continuously -> 3 read passes total, rd_sel sequence 0,1,2, three o_intr pulses; second pass has top row = line 1.
- Push 4*512 pixels with no reads possible (hold i_rst low but stall? use count preload via 4 lines back-to-back while READ active), then one extra pixel while full -> o_overflow=1 and stays 1; count stays 2048.
- Assert i_rst for one cycle midway through a READ pass -> next cycle all outputs 0 and FSM IDLE; no o_intr; a fresh 3-line stream then yields correct windows starting at column 0.
